// File: rtl/game_overlay_streamer.sv
// Game-over overlay renderer: latches result flags on start, fetches text rows from a sync ROM,
// streams pixels over valid/ready. Define OVERLAY_BORDER_EN to draw a 1-pixel frame around the overlay.
module game_overlay_streamer #(
  parameter int COLS       = 100,
  parameter int HDR_ROWS   = 7,
  parameter int MOT_ROWS   = 7,
  parameter int RES_ROWS   = 5,
  parameter int GAP_ROWS   = 2,
  parameter int N_VARIANTS = 3,
  parameter int MSG_W      = 4,
  localparam int TOTAL     = HDR_ROWS + MOT_ROWS + RES_ROWS + 2 * GAP_ROWS,
  localparam int MAX_ROWS  = (HDR_ROWS > MOT_ROWS) ? ((HDR_ROWS > RES_ROWS) ? HDR_ROWS : RES_ROWS)
                                                   : ((MOT_ROWS > RES_ROWS) ? MOT_ROWS : RES_ROWS),
  localparam int ROW_W     = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1,
  localparam int X_W       = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int Y_W       = (TOTAL > 1) ? $clog2(TOTAL) : 1,
  localparam int VC_W      = (N_VARIANTS > 1) ? $clog2(N_VARIANTS) : 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             is_win,
  input  logic             is_high_score,
  output logic             busy,
  output logic             done,
  output logic             rom_rd,
  output logic [MSG_W-1:0] rom_msg,
  output logic [ROW_W-1:0] rom_row,
  input  logic [COLS-1:0]  rom_data,
  output logic             px_valid,
  input  logic             px_ready,
  output logic [X_W-1:0]   px_x,
  output logic [Y_W-1:0]   px_y,
  output logic             px_on
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_EMIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [Y_W-1:0]  HDR_END = Y_W'(HDR_ROWS);
  localparam logic [Y_W-1:0]  MOT_Y   = Y_W'(HDR_ROWS + GAP_ROWS);
  localparam logic [Y_W-1:0]  MOT_END = Y_W'(HDR_ROWS + GAP_ROWS + MOT_ROWS);
  localparam logic [Y_W-1:0]  RES_Y   = Y_W'(HDR_ROWS + 2 * GAP_ROWS + MOT_ROWS);
  localparam logic [Y_W-1:0]  Y_LAST  = Y_W'(TOTAL - 1);
  localparam logic [X_W-1:0]  X_LAST  = X_W'(COLS - 1);
  localparam logic [VC_W-1:0] VC_LAST = VC_W'(N_VARIANTS - 1);

  logic [2:0]      state_q, state_d;
  logic [VC_W-1:0] vc_q, vc_d, v_q, v_d;
  logic            win_q, win_d, hs_q, hs_d;
  logic [X_W-1:0]  x_q, x_d;
  logic [Y_W-1:0]  y_q, y_d;
  logic [COLS-1:0] shreg_q, shreg_d;

  logic             row_text;
  logic [MSG_W-1:0] row_msg, mot_msg;
  logic [ROW_W-1:0] row_idx;
  logic             border;

  // Win outranks high score for both the motivation line and the result banner.
  assign mot_msg = win_q ? MSG_W'(3)
                 : hs_q  ? MSG_W'(4) + MSG_W'(v_q)
                 :         MSG_W'(4 + N_VARIANTS) + MSG_W'(v_q);

  always_comb begin
    row_text = 1'b0;
    row_msg  = '0;
    row_idx  = '0;
    if (y_q < HDR_END) begin
      row_text = 1'b1;
      row_idx  = ROW_W'(y_q);
    end else if (y_q >= MOT_Y && y_q < MOT_END) begin
      row_text = 1'b1;
      row_msg  = mot_msg;
      row_idx  = ROW_W'(y_q - MOT_Y);
    end else if (y_q >= RES_Y) begin
      row_text = win_q | hs_q;
      row_msg  = win_q ? MSG_W'(1) : MSG_W'(2);
      row_idx  = ROW_W'(y_q - RES_Y);
    end
  end

  always_comb begin
    vc_d    = (vc_q == VC_LAST) ? '0 : vc_q + 1'b1;
    state_d = state_q;
    v_d     = v_q;
    win_d   = win_q;
    hs_d    = hs_q;
    x_d     = x_q;
    y_d     = y_q;
    shreg_d = shreg_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          win_d   = is_win;
          hs_d    = is_high_score;
          v_d     = vc_q;
          x_d     = '0;
          y_d     = '0;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        state_d = S_EMIT;
        shreg_d = row_text ? rom_data : '0;
      end
      S_EMIT: begin
        // MSB of the shift register is always the pixel at x_q.
        if (px_ready) begin
          shreg_d = shreg_q << 1;
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              state_d = S_DONE;
            end else begin
              y_d     = y_q + 1'b1;
              state_d = S_FETCH;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        y_d     = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      vc_q    <= '0;
      v_q     <= '0;
      win_q   <= 1'b0;
      hs_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      vc_q    <= vc_d;
      v_q     <= v_d;
      win_q   <= win_d;
      hs_q    <= hs_d;
      x_q     <= x_d;
      y_q     <= y_d;
      shreg_q <= shreg_d;
    end
  end

`ifdef OVERLAY_BORDER_EN
  assign border = (x_q == '0) || (x_q == X_LAST) || (y_q == '0) || (y_q == Y_LAST);
`else
  assign border = 1'b0;
`endif

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign rom_rd   = (state_q == S_FETCH) && row_text;
  assign rom_msg  = rom_rd ? row_msg : '0;
  assign rom_row  = rom_rd ? row_idx : '0;
  assign px_valid = (state_q == S_EMIT);
  assign px_x     = x_q;
  assign px_y     = y_q;
  assign px_on    = px_valid && (shreg_q[COLS-1] || border);

endmodule

// File: tb/tb_game_overlay_streamer.sv
// Directed bench for game_overlay_streamer: ROM model, per-pixel reference, read-sequence and timing checks.
module tb_game_overlay_streamer;
  localparam int COLS  = 100;
  localparam int TOTAL = 23;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic         is_win = 1'b0;
  logic         is_high_score = 1'b0;
  logic         px_ready = 1'b1;
  logic         busy, done, rom_rd, px_valid, px_on;
  logic [3:0]   rom_msg;
  logic [2:0]   rom_row;
  logic [99:0]  rom_data = '0;
  logic [6:0]   px_x;
  logic [4:0]   px_y;

  int checks = 0;
  int errors = 0;
  int m_vc;
  int cyc = 0;
  int start_cyc, first_vld_cyc, done_cyc;
  int exp_x, exp_y, pix_cnt;
  int f_mot, f_res;
  bit hold_prev = 1'b0;
  logic [13:0] prev_vec = '0;
  int msg_q[$];
  int row_q[$];

  always #5 clock = ~clock;

  game_overlay_streamer dut (
    .clock(clock), .resetn(resetn), .start(start), .is_win(is_win),
    .is_high_score(is_high_score), .busy(busy), .done(done), .rom_rd(rom_rd),
    .rom_msg(rom_msg), .rom_row(rom_row), .rom_data(rom_data), .px_valid(px_valid),
    .px_ready(px_ready), .px_x(px_x), .px_y(px_y), .px_on(px_on)
  );

  function automatic logic [99:0] rom_pat(int msg, int row);
    logic [99:0] p;
    for (int i = 0; i < 100; i++) p[i] = ((i * (msg + 2) + row * 7 + msg * 3) % 11) < 4;
    return p;
  endfunction

  always @(posedge clock) if (rom_rd) rom_data <= rom_pat(int'(rom_msg), int'(rom_row));

  always @(posedge clock or negedge resetn)
    if (!resetn) m_vc <= 0;
    else         m_vc <= (m_vc == 2) ? 0 : m_vc + 1;

  // Reference layout: HDR 0..6, gap 7..8, MOT 9..15, gap 16..17, RES 18..22.
  function automatic logic exp_on(int x, int y);
    int msg;
    int row;
    logic [99:0] p;
    logic b;
    msg = -1;
    row = 0;
    if (y < 7) begin msg = 0; row = y; end
    else if (y >= 9 && y < 16) begin msg = f_mot; row = y - 9; end
    else if (y >= 18) begin msg = f_res; row = y - 18; end
    p = rom_pat(msg, row);
    b = (msg >= 0) ? p[99 - x] : 1'b0;
`ifdef OVERLAY_BORDER_EN
    b = b | (x == 0) | (x == COLS - 1) | (y == 0) | (y == TOTAL - 1);
`endif
    return b;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cycle();
    @(negedge clock);
    cyc++;
    if (hold_prev) chk("hold_stable", {px_valid, px_x, px_y, px_on}, prev_vec);
    hold_prev = px_valid && !px_ready;
    prev_vec  = {px_valid, px_x, px_y, px_on};
    if (rom_rd) begin msg_q.push_back(int'(rom_msg)); row_q.push_back(int'(rom_row)); end
    if (px_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (done && done_cyc < 0) done_cyc = cyc;
    if (px_valid && px_ready) begin
      chk("pixel", {px_x, px_y, px_on}, {7'(exp_x), 5'(exp_y), exp_on(exp_x, exp_y)});
      pix_cnt++;
      exp_x++;
      if (exp_x == COLS) begin exp_x = 0; exp_y++; end
    end
    @(posedge clock);
    #2;
  endtask

  task automatic start_frame(input logic w, input logic h, input int mot, input int res);
    f_mot = mot; f_res = res;
    exp_x = 0; exp_y = 0; pix_cnt = 0;
    msg_q.delete(); row_q.delete();
    first_vld_cyc = -1; done_cyc = -1;
    chk("idle_before_start", busy, 0);
    is_win = w; is_high_score = h; start = 1'b1;
    start_cyc = cyc + 1;
    cycle();
    start = 1'b0; is_win = 1'b0; is_high_score = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("fetch_first", {rom_rd, rom_msg, rom_row}, {1'b1, 4'd0, 3'd0});
  endtask

  task automatic run_frame(input logic w, input logic h, input int mot, input int res,
                           input int vc_want, input int stall_y, input bit mid_start);
    int budget;
    int stall_left;
    bit stalled;
    int n_rd;
    int em;
    int er;
    stall_left = 0;
    stalled = 1'b0;
    if (vc_want >= 0) begin
      budget = 0;
      while (m_vc != vc_want && budget < 10) begin cycle(); budget++; end
      chk("vc_sync", m_vc, vc_want);
    end
    start_frame(w, h, mot, res);
    budget = 0;
    while (done_cyc < 0 && budget < 3000) begin
      if (stall_y >= 0 && !stalled && px_valid && px_x == 7'd40 && px_y == 5'(stall_y)) begin
        px_ready = 1'b0; stalled = 1'b1; stall_left = 5;
      end else if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) px_ready = 1'b1;
      end
      if (mid_start && cyc == start_cyc + 500) begin start = 1'b1; is_win = 1'b1; end
      else begin start = 1'b0; is_win = 1'b0; end
      cycle();
      budget++;
    end
    px_ready = 1'b1;
    start = 1'b0; is_win = 1'b0;
    chk("done_seen", done_cyc >= 0, 1);
    chk("done_pulse_end", {done, busy}, 2'b00);
    chk("pix_count", pix_cnt, 2300);
    chk("first_valid_cyc", first_vld_cyc, start_cyc + 3);
    chk("done_cyc", done_cyc, start_cyc + 2347 + (stalled ? 5 : 0));
    n_rd = (res >= 0) ? 19 : 14;
    chk("rd_count", msg_q.size(), n_rd);
    for (int i = 0; i < msg_q.size() && i < n_rd; i++) begin
      if (i < 7) begin em = 0; er = i; end
      else if (i < 14) begin em = mot; er = i - 7; end
      else begin em = res; er = i - 14; end
      chk("rd_seq", msg_q[i] * 16 + row_q[i], em * 16 + er);
    end
    if (mid_start) begin
      repeat (3) cycle();
      chk("no_queued_start", busy, 0);
    end
  endtask

  initial begin
    int budget;
    #12;
    chk("reset_outputs", {busy, done, rom_rd, px_valid, px_on, px_x, px_y}, 0);
    @(posedge clock);
    #2;
    resetn = 1'b1;
    cycle();
    chk("post_reset_idle", {busy, done, rom_rd, px_valid}, 0);

    // Win: GAME OVER, win motivation, WIN banner.
    run_frame(1'b1, 1'b0, 3, 1, -1, -1, 1'b0);
    // High score with variant 1 -> success variant id 5.
    run_frame(1'b0, 1'b1, 5, 2, 1, -1, 1'b0);
    // Both flags: win wins.
    run_frame(1'b1, 1'b1, 3, 1, -1, -1, 1'b0);
    // Neither flag, variant 2 -> motivation id 9, blank result banner.
    run_frame(1'b0, 1'b0, 9, -1, 2, -1, 1'b0);
    // Backpressure at (40,3) for 5 cycles plus an ignored mid-frame start.
    run_frame(1'b1, 1'b0, 3, 1, -1, 3, 1'b1);

    // Reset during row 10 abandons the frame.
    start_frame(1'b1, 1'b0, 3, 1);
    budget = 0;
    while (px_y != 5'd10 && budget < 2000) begin cycle(); budget++; end
    chk("reach_row10", px_y, 10);
    resetn = 1'b0;
    #1;
    chk("async_reset_outputs", {busy, done, rom_rd, px_valid, px_on, px_x, px_y, rom_msg, rom_row}, 0);
    hold_prev = 1'b0;
    cycle();
    cycle();
    resetn = 1'b1;
    cycle();
    chk("idle_after_reset", {busy, px_valid}, 0);
    run_frame(1'b0, 1'b1, 4, 2, 0, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
